// File: rtl/demux32_fifo.sv
// Routes each 32-bit word on A into one of two output FIFOs chosen by S.
// Latency: a word pushed into an empty queue shows on Yk one cycle after the push edge.
// Backpressure: in_ready drops when the selected queue is full and stays low even if
// that queue pops in the same cycle; each output drains under its own yk_valid/yk_ready handshake.
// Ports: clk, reset (async, active-high); A/S/in_valid/in_ready (input side);
//        Yk/yk_valid/yk_ready (output channel k); lvl0/lvl1 (queue occupancy).
module demux32_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              A,
    input  logic                     S,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [31:0]              Y0,
    output logic                     y0_valid,
    input  logic                     y0_ready,
    output logic [31:0]              Y1,
    output logic                     y1_valid,
    input  logic                     y1_ready,
    output logic [$clog2(DEPTH):0]   lvl0,
    output logic [$clog2(DEPTH):0]   lvl1
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // Storage is never reset: the pointers and levels define what is valid.
    logic [31:0] mem0_q [DEPTH];
    logic [31:0] mem1_q [DEPTH];

    logic [AW-1:0] wp0_q, rp0_q, wp1_q, rp1_q;
    logic [AW-1:0] wp0_d, rp0_d, wp1_d, rp1_d;
    logic [LW-1:0] lvl0_q, lvl1_q;
    logic [LW-1:0] lvl0_d, lvl1_d;

    logic full0, full1;
    logic push0, push1, pop0, pop1;

    assign full0 = (lvl0_q == FULL_LVL);
    assign full1 = (lvl1_q == FULL_LVL);

    // Readiness looks only at the level register, so a pop in the same cycle
    // cannot free a slot for the incoming word.
    assign in_ready = S ? ~full1 : ~full0;

    assign push0 = in_valid & in_ready & ~S;
    assign push1 = in_valid & in_ready &  S;

    assign y0_valid = (lvl0_q != '0);
    assign y1_valid = (lvl1_q != '0);

    assign pop0 = y0_valid & y0_ready;
    assign pop1 = y1_valid & y1_ready;

    // Outputs are forced to zero when empty so stale storage never leaks out.
    assign Y0 = y0_valid ? mem0_q[rp0_q] : 32'h0;
    assign Y1 = y1_valid ? mem1_q[rp1_q] : 32'h0;

    assign lvl0 = lvl0_q;
    assign lvl1 = lvl1_q;

    always_comb begin
        // DEPTH is a power of two, so the natural pointer overflow is the wrap.
        wp0_d  = push0 ? wp0_q + AW'(1) : wp0_q;
        rp0_d  = pop0  ? rp0_q + AW'(1) : rp0_q;
        wp1_d  = push1 ? wp1_q + AW'(1) : wp1_q;
        rp1_d  = pop1  ? rp1_q + AW'(1) : rp1_q;

        lvl0_d = lvl0_q;
        case ({push0, pop0})
            2'b10:   lvl0_d = lvl0_q + LW'(1);
            2'b01:   lvl0_d = lvl0_q - LW'(1);
            default: lvl0_d = lvl0_q;
        endcase

        lvl1_d = lvl1_q;
        case ({push1, pop1})
            2'b10:   lvl1_d = lvl1_q + LW'(1);
            2'b01:   lvl1_d = lvl1_q - LW'(1);
            default: lvl1_d = lvl1_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp0_q  <= '0;
            rp0_q  <= '0;
            wp1_q  <= '0;
            rp1_q  <= '0;
            lvl0_q <= '0;
            lvl1_q <= '0;
        end else begin
            wp0_q  <= wp0_d;
            rp0_q  <= rp0_d;
            wp1_q  <= wp1_d;
            rp1_q  <= rp1_d;
            lvl0_q <= lvl0_d;
            lvl1_q <= lvl1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push0) begin
            mem0_q[wp0_q] <= A;
        end
        if (push1) begin
            mem1_q[wp1_q] <= A;
        end
    end

endmodule

// File: tb/tb_demux32_fifo.sv
// Directed bench for demux32_fifo with DEPTH=2.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_demux32_fifo;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic        S;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Y0;
    logic        y0_valid;
    logic        y0_ready;
    logic [31:0] Y1;
    logic        y1_valid;
    logic        y1_ready;
    logic [1:0]  lvl0;
    logic [1:0]  lvl1;

    int n_checks;
    int n_pass;

    demux32_fifo #(.DEPTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .S        (S),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Y0       (Y0),
        .y0_valid (y0_valid),
        .y0_ready (y0_ready),
        .Y1       (Y1),
        .y1_valid (y1_valid),
        .y1_ready (y1_ready),
        .lvl0     (lvl0),
        .lvl1     (lvl1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        y0_ready = 1'b0;
        y1_ready = 1'b0;
        A        = 32'h0;
        S        = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        n_checks++; if (y0_valid !== 1'b0) $display("FAIL reset_y0_valid got %0b exp 0", y0_valid); else n_pass++;
        n_checks++; if (y1_valid !== 1'b0) $display("FAIL reset_y1_valid got %0b exp 0", y1_valid); else n_pass++;
        n_checks++; if (Y0 !== 32'h0) $display("FAIL reset_Y0 got %h exp 0", Y0); else n_pass++;
        n_checks++; if (Y1 !== 32'h0) $display("FAIL reset_Y1 got %h exp 0", Y1); else n_pass++;
        n_checks++; if (lvl0 !== 2'd0 || lvl1 !== 2'd0) $display("FAIL reset_lvl got %0d/%0d exp 0/0", lvl0, lvl1); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", in_ready); else n_pass++;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_push();
        in_valid = 1'b1; A = 32'h11; S = 1'b0;
        #1;
        n_checks++; if (y0_valid !== 1'b0 || Y0 !== 32'h0) $display("FAIL single_no_comb_path got v=%0b Y0=%h exp v=0 Y0=0", y0_valid, Y0); else n_pass++;
        step();
        in_valid = 1'b0;
        n_checks++; if (y0_valid !== 1'b1) $display("FAIL single_y0_valid got %0b exp 1", y0_valid); else n_pass++;
        n_checks++; if (Y0 !== 32'h11) $display("FAIL single_Y0 got %h exp 00000011", Y0); else n_pass++;
        n_checks++; if (lvl0 !== 2'd1) $display("FAIL single_lvl0 got %0d exp 1", lvl0); else n_pass++;
        n_checks++; if (y1_valid !== 1'b0 || Y1 !== 32'h0) $display("FAIL single_ch1_idle got v=%0b Y1=%h exp v=0 Y1=0", y1_valid, Y1); else n_pass++;
        y0_ready = 1'b1;
        step();
        y0_ready = 1'b0;
        n_checks++; if (lvl0 !== 2'd0 || Y0 !== 32'h0) $display("FAIL single_drain got lvl0=%0d Y0=%h exp 0/0", lvl0, Y0); else n_pass++;
    endtask

    task automatic test_full_ch1();
        in_valid = 1'b1; S = 1'b1; A = 32'hA;
        step();
        A = 32'hB;
        step();
        in_valid = 1'b0;
        n_checks++; if (lvl1 !== 2'd2) $display("FAIL full1_lvl1 got %0d exp 2", lvl1); else n_pass++;
        S = 1'b1; #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full1_ready_s1 got %0b exp 0", in_ready); else n_pass++;
        S = 1'b0; #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL full1_ready_s0 got %0b exp 1", in_ready); else n_pass++;
        // Push to a full queue must be ignored.
        S = 1'b1; in_valid = 1'b1; A = 32'hFF;
        step();
        in_valid = 1'b0;
        n_checks++; if (lvl1 !== 2'd2 || lvl0 !== 2'd0) $display("FAIL full1_reject got lvl1=%0d lvl0=%0d exp 2/0", lvl1, lvl0); else n_pass++;
        y1_ready = 1'b1;
        n_checks++; if (Y1 !== 32'hA) $display("FAIL full1_head0 got %h exp 0000000a", Y1); else n_pass++;
        step();
        n_checks++; if (Y1 !== 32'hB || lvl1 !== 2'd1) $display("FAIL full1_head1 got Y1=%h lvl1=%0d exp 0000000b/1", Y1, lvl1); else n_pass++;
        step();
        n_checks++; if (lvl1 !== 2'd0 || y1_valid !== 1'b0) $display("FAIL full1_empty got lvl1=%0d v=%0b exp 0/0", lvl1, y1_valid); else n_pass++;
        // Ready on an empty queue must not underflow.
        step();
        y1_ready = 1'b0;
        n_checks++; if (lvl1 !== 2'd0) $display("FAIL full1_no_underflow got %0d exp 0", lvl1); else n_pass++;
    endtask

    task automatic test_no_full_bypass();
        in_valid = 1'b1; S = 1'b0; A = 32'h21;
        step();
        A = 32'h22;
        step();
        A = 32'h23; y0_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bypass_ready got %0b exp 0", in_ready); else n_pass++;
        step();
        in_valid = 1'b0; y0_ready = 1'b0;
        n_checks++; if (lvl0 !== 2'd1 || Y0 !== 32'h22) $display("FAIL bypass_result got lvl0=%0d Y0=%h exp 1/00000022", lvl0, Y0); else n_pass++;
        y0_ready = 1'b1;
        step();
        y0_ready = 1'b0;
        n_checks++; if (lvl0 !== 2'd0) $display("FAIL bypass_drain got %0d exp 0", lvl0); else n_pass++;
    endtask

    task automatic test_stream_wrap();
        y0_ready = 1'b1; S = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            A = 32'(i);
            if (i > 1) begin
                n_checks++; if (Y0 !== 32'(i - 1)) $display("FAIL stream_Y0_%0d got %h exp %h", i - 1, Y0, 32'(i - 1)); else n_pass++;
            end
            step();
            n_checks++; if (lvl0 !== 2'd1) $display("FAIL stream_lvl0_%0d got %0d exp 1", i, lvl0); else n_pass++;
        end
        in_valid = 1'b0;
        n_checks++; if (Y0 !== 32'd7) $display("FAIL stream_Y0_7 got %h exp 00000007", Y0); else n_pass++;
        step();
        y0_ready = 1'b0;
        n_checks++; if (lvl0 !== 2'd0) $display("FAIL stream_drain got %0d exp 0", lvl0); else n_pass++;
    endtask

    task automatic test_alternate();
        logic [31:0] got0[$];
        logic [31:0] got1[$];
        y0_ready = 1'b1; y1_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8);
            S = i[0];
            A = 32'hC0DE0000 + 32'(i);
            if (y0_valid) got0.push_back(Y0);
            if (y1_valid) got1.push_back(Y1);
            step();
        end
        idle_inputs();
        n_checks++; if (got0.size() != 4 || got1.size() != 4) $display("FAIL alt_counts got %0d/%0d exp 4/4", got0.size(), got1.size()); else n_pass++;
        for (int k = 0; k < 4 && k < got0.size() && k < got1.size(); k++) begin
            n_checks++; if (got0[k] !== 32'hC0DE0000 + 32'(2 * k)) $display("FAIL alt_ch0_%0d got %h exp %h", k, got0[k], 32'hC0DE0000 + 32'(2 * k)); else n_pass++;
            n_checks++; if (got1[k] !== 32'hC0DE0001 + 32'(2 * k)) $display("FAIL alt_ch1_%0d got %h exp %h", k, got1[k], 32'hC0DE0001 + 32'(2 * k)); else n_pass++;
        end
        n_checks++; if (lvl0 !== 2'd0 || lvl1 !== 2'd0) $display("FAIL alt_drained got %0d/%0d exp 0/0", lvl0, lvl1); else n_pass++;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; S = 1'b0; A = 32'h31;
        step();
        A = 32'h32;
        step();
        S = 1'b1; A = 32'h41;
        step();
        in_valid = 1'b0;
        n_checks++; if (lvl0 !== 2'd2 || lvl1 !== 2'd1) $display("FAIL arst_pre got %0d/%0d exp 2/1", lvl0, lvl1); else n_pass++;
        #3;
        reset = 1'b1;
        #1;
        n_checks++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0) $display("FAIL arst_valid got %0b/%0b exp 0/0", y0_valid, y1_valid); else n_pass++;
        n_checks++; if (lvl0 !== 2'd0 || lvl1 !== 2'd0) $display("FAIL arst_lvl got %0d/%0d exp 0/0", lvl0, lvl1); else n_pass++;
        n_checks++; if (Y0 !== 32'h0 || Y1 !== 32'h0) $display("FAIL arst_Y got %h/%h exp 0/0", Y0, Y1); else n_pass++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_after_reset_cross();
        in_valid = 1'b1; S = 1'b1; A = 32'h55;
        step();
        n_checks++; if (lvl1 !== 2'd1 || Y1 !== 32'h55) $display("FAIL post_reset_push got lvl1=%0d Y1=%h exp 1/00000055", lvl1, Y1); else n_pass++;
        // Push channel 0 while channel 1 pops in the same cycle.
        S = 1'b0; A = 32'h66; y1_ready = 1'b1;
        step();
        idle_inputs();
        n_checks++; if (lvl0 !== 2'd1 || lvl1 !== 2'd0 || Y0 !== 32'h66) $display("FAIL cross got lvl0=%0d lvl1=%0d Y0=%h exp 1/0/00000066", lvl0, lvl1, Y0); else n_pass++;
        // Push and pop on the same non-full, non-empty queue.
        in_valid = 1'b1; S = 1'b0; A = 32'h77; y0_ready = 1'b1;
        step();
        idle_inputs();
        n_checks++; if (lvl0 !== 2'd1 || Y0 !== 32'h77) $display("FAIL same_q got lvl0=%0d Y0=%h exp 1/00000077", lvl0, Y0); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_single_push();
        test_full_ch1();
        test_no_full_bypass();
        test_stream_wrap();
        test_alternate();
        test_async_reset();
        test_after_reset_cross();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux32_fifo.md
DEMUX32_FIFO -- requirements
Module: demux32_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning entries per output queue (power of two, >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port A, input, 32 bits: data word to route.
REQ-005 The block SHALL have port S, input, 1 bit: destination select (0 -> channel 0, 1 -> channel 1).
REQ-006 The block SHALL have port in_valid, input, 1 bit: A/S valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the queue selected by S can accept.
REQ-008 The block SHALL have port Y0, output, 32 bits: channel 0 head word.
REQ-009 The block SHALL have port y0_valid, output, 1 bit: channel 0 queue non-empty.
REQ-010 The block SHALL have port y0_ready, input, 1 bit: channel 0 consumer accepts.
REQ-011 The block SHALL have ports Y1, y1_valid and y1_ready: same widths and meanings for channel 1.
REQ-012 The block SHALL have ports lvl0 and lvl1, outputs, $clog2(DEPTH)+1 bits: occupancy of each queue.

Function
REQ-013 Push: in_valid=1 and in_ready=1 at a rising edge SHALL write A into queue S only; the other queue is untouched.
REQ-014 in_ready SHALL be combinational: 1 iff lvl of the queue selected by current S < DEPTH; no dependence on in_valid or yk_ready.
REQ-015 Full queue: in_ready SHALL be 0 even if that queue pops in the same cycle (no full-bypass).
REQ-016 Pop k: yk_valid=1 and yk_ready=1 at a rising edge SHALL remove the head of queue k.
REQ-017 yk_valid SHALL equal (lvlk != 0); Yk SHALL equal the head entry when yk_valid=1 and 32'h0 when yk_valid=0.
REQ-018 Latency: a word pushed into an empty queue SHALL appear on Yk with yk_valid=1 on the cycle after the push edge; no same-cycle combinational path from A to Yk.
REQ-019 Order: each queue SHALL be strictly FIFO; words routed to different channels carry no relative ordering.
REQ-020 Simultaneous push and pop on the same non-full, non-empty queue SHALL leave lvlk unchanged and both take effect.
REQ-021 Push to queue 0 and pop from queue 1 (or vice versa) in the same cycle SHALL both take effect independently.
REQ-022 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no lost or duplicated entry.
REQ-023 yk_ready while yk_valid=0 SHALL have no effect; in_valid while in_ready=0 SHALL have no effect.
REQ-024 lvlk SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-025 reset=1 SHALL immediately (without clk) clear both pointers and lvl0=lvl1=0, giving y0_valid=y1_valid=0, Y0=Y1=32'h0, in_ready=1.
REQ-026 Reset asserted mid-operation SHALL discard all queued words; queue storage contents need not be cleared.
REQ-027 After reset deassertion, the first clk edge with in_valid=1 SHALL be accepted normally.

Verification
REQ-028 DEPTH=2: push A=32'h11 S=0, next cycle -> y0_valid=1, Y0=32'h11, lvl0=1, y1_valid=0, Y1=0.
REQ-029 Push 32'hA,32'hB to S=1 with y1_ready=0 -> lvl1=2, in_ready=0 while S=1, in_ready=1 while S=0; then y1_ready=1 -> Y1=32'hA then 32'hB, lvl1 2->1->0.
REQ-030 Queue 0 full (2 entries), push S=0 with y0_ready=1 same cycle -> push rejected, pop done, lvl0=1.
REQ-031 Stream 7 words 1..7 to S=0 with y0_ready=1 every cycle -> Y0 outputs 1..7 in order across pointer wrap, lvl0 holds at 1.
REQ-032 Alternate S=0/S=1 pushes of 32'hC0DE0000+i while both queues drain -> each channel receives its own words in order, none lost.
REQ-033 Assert reset asynchronously between edges with lvl0=2, lvl1=1 -> same instant y0_valid=y1_valid=0, lvl0=lvl1=0, Y0=Y1=0.
